// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state encodings,
// ALU opcode values and flag bit positions within the {N,Z,C,V,P} vector.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } alu_seq_state_e;

  localparam logic [1:0] OP_SUB = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  localparam int FLG_N = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_P = 0;

endpackage

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode from switches, drives the external ALU and latches its
// result. Optional macro ALU_SEQ_CHAIN_EN: enter in SHOW feeds result back as A.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int M     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [M-1:0]     data_in,
  input  logic             enter,
  input  logic             undo,
  output logic [M-1:0]     alu_a,
  output logic [M-1:0]     alu_b,
  output logic [1:0]       alu_opcode,
  input  logic [M-1:0]     alu_result,
  input  logic [4:0]       alu_flags,
  output logic [M-1:0]     result,
  output logic [4:0]       flags,
  output logic             result_valid,
  output logic [2:0]       stage,
  output logic [M-1:0]     display,
  output logic [CNT_W-1:0] op_count
);

  alu_seq_state_e   state_q, state_d;
  logic [M-1:0]     a_q, a_d;
  logic [M-1:0]     b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [M-1:0]     res_q, res_d;
  logic [4:0]       flg_q, flg_d;
  logic             rv_q, rv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      rv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      rv_q    <= rv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Undo always takes priority over a simultaneous enter.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flg_d   = flg_q;
    rv_d    = rv_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_A: begin
        if (!undo && enter) begin
          a_d     = data_in;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (undo) begin
          state_d = ST_WAIT_A;
        end else if (enter) begin
          b_d     = data_in;
          state_d = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (undo) begin
          state_d = ST_WAIT_B;
        end else if (enter) begin
          op_d    = data_in[1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_result;
        flg_d   = alu_flags;
        rv_d    = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (undo) begin
          rv_d    = 1'b0;
          state_d = ST_WAIT_OP;
        end else if (enter) begin
          rv_d    = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
          a_d     = res_q;
          state_d = ST_WAIT_B;
`else
          state_d = ST_WAIT_A;
`endif
        end
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_opcode   = op_q;
  assign result       = res_q;
  assign flags        = flg_q;
  assign result_valid = rv_q;
  assign op_count     = cnt_q;
  assign stage        = state_q;
  assign display      = (state_q == ST_SHOW) ? res_q : data_in;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a behavioural ALU beside it.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int M     = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [M-1:0]     data_in = '0;
  logic             enter = 1'b0;
  logic             undo = 1'b0;
  logic [M-1:0]     alu_a, alu_b;
  logic [1:0]       alu_opcode;
  logic [M-1:0]     alu_result;
  logic [4:0]       alu_flags;
  logic [M-1:0]     result;
  logic [4:0]       flags;
  logic             result_valid;
  logic [2:0]       stage;
  logic [M-1:0]     display;
  logic [CNT_W-1:0] op_count;

  alu_operand_sequencer #(.M(M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .enter(enter), .undo(undo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .result(result), .flags(flags), .result_valid(result_valid),
    .stage(stage), .display(display), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the team ALU; C is the borrow bit on subtract.
  always_comb begin
    logic [M:0] wide;
    wide = '0;
    alu_flags = '0;
    case (alu_opcode)
      OP_SUB: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        alu_flags[FLG_V] = (alu_a[M-1] != alu_b[M-1]) && (wide[M-1] != alu_a[M-1]);
        alu_flags[FLG_C] = wide[M];
      end
      OP_ADD: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_flags[FLG_V] = (alu_a[M-1] == alu_b[M-1]) && (wide[M-1] != alu_a[M-1]);
        alu_flags[FLG_C] = wide[M];
      end
      OP_OR:   wide = {1'b0, alu_a | alu_b};
      default: wide = {1'b0, alu_a & alu_b};
    endcase
    alu_result = wide[M-1:0];
    alu_flags[FLG_N] = wide[M-1];
    alu_flags[FLG_Z] = (wide[M-1:0] == '0);
    alu_flags[FLG_P] = ^wide[M-1:0];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [M-1:0]     res;
    logic [4:0]       flg;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every rising edge of result_valid consumes one expected entry.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_flags", flags, e.flg);
        chk("sb_op_count", op_count, e.cnt);
      end
    end
    rv_prev = result_valid;
  end

  task automatic pulse(input logic [M-1:0] v, input logic e, input logic u);
    @(negedge clk);
    data_in = v;
    enter   = e;
    undo    = u;
    @(posedge clk);
    #1;
    enter = 1'b0;
    undo  = 1'b0;
  endtask

  task automatic expect_op(input logic [M-1:0] r, input logic [4:0] f);
    exp_t e;
    exp_cnt = exp_cnt + 1'b1;
    e.res = r;
    e.flg = f;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  // Issue the op-code enter from WAIT_OP and check the two-edge latency.
  task automatic fire_op(input logic [1:0] op, input logic [M-1:0] r, input logic [4:0] f);
    expect_op(r, f);
    pulse({6'd0, op}, 1'b1, 1'b0);
    chk("exec_stage", stage, 32'd3);
    chk("exec_rv", result_valid, 32'd0);
    @(posedge clk);
    #1;
    chk("show_stage", stage, 32'd4);
    chk("show_rv", result_valid, 32'd1);
    chk("show_display", display, r);
  endtask

  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [1:0] op,
                        input logic [M-1:0] r, input logic [4:0] f);
    pulse(a, 1'b1, 1'b0);
    pulse(b, 1'b1, 1'b0);
    fire_op(op, r, f);
  endtask

  task automatic leave_show();
    pulse(8'h00, 1'b1, 1'b0);
`ifdef ALU_SEQ_CHAIN_EN
    pulse(8'h00, 1'b0, 1'b1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stage", stage, 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    chk("rst_rv", result_valid, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;

    // Subtract, then undo from SHOW and re-execute the same operands.
    run_op(8'h05, 8'h03, 2'd0, 8'h02, 5'b00001);
    pulse(8'h00, 1'b0, 1'b1);
    chk("undo_show_stage", stage, 32'd2);
    chk("undo_show_rv", result_valid, 32'd0);
    chk("undo_show_result", result, 32'h02);
    fire_op(2'd0, 8'h02, 5'b00001);
    leave_show();

    run_op(8'hFF, 8'h01, 2'd1, 8'h00, 5'b01100);
    leave_show();
    run_op(8'h03, 8'h05, 2'd0, 8'hFE, 5'b10101);
    leave_show();
    run_op(8'h7F, 8'h01, 2'd1, 8'h80, 5'b10011);
    leave_show();
    run_op(8'hF0, 8'h0C, 2'd2, 8'hFC, 5'b10000);
    leave_show();
    run_op(8'hF0, 8'h0C, 2'd3, 8'h00, 5'b01000);
    leave_show();

    // Undo walk and simultaneous enter/undo.
    pulse(8'h5A, 1'b1, 1'b0);
    pulse(8'h3C, 1'b1, 1'b0);
    chk("walk_stage_op", stage, 32'd2);
    pulse(8'h00, 1'b0, 1'b1);
    chk("undo_op_stage", stage, 32'd1);
    pulse(8'h00, 1'b0, 1'b1);
    chk("undo_b_stage", stage, 32'd0);
    pulse(8'h00, 1'b0, 1'b1);
    chk("undo_a_stage", stage, 32'd0);
    chk("undo_a_kept", alu_a, 32'h5A);
    pulse(8'h5A, 1'b1, 1'b0);
    pulse(8'h99, 1'b1, 1'b1);
    chk("both_stage", stage, 32'd0);
    chk("both_b_kept", alu_b, 32'h3C);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_stage", stage, 32'd0);
    data_in = 8'h6B;
    #1;
    chk("display_passthru", display, 32'h6B);

    // Asynchronous reset between the op enter and the EXEC edge.
    pulse(8'h11, 1'b1, 1'b0);
    pulse(8'h22, 1'b1, 1'b0);
    pulse(8'h01, 1'b1, 1'b0);
    chk("pre_rst_stage", stage, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_stage", stage, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", flags, 32'd0);
    chk("midrst_rv", result_valid, 32'd0);
    chk("midrst_op_count", op_count, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    #1 rst_n = 1'b1;
    exp_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_rv", result_valid, 32'd0);

    // Enter in SHOW: chaining variant vs plain return to WAIT_A.
    run_op(8'h05, 8'h03, 2'd0, 8'h02, 5'b00001);
    pulse(8'hAA, 1'b1, 1'b0);
`ifdef ALU_SEQ_CHAIN_EN
    chk("chain_stage", stage, 32'd1);
    chk("chain_alu_a", alu_a, 32'h02);
    pulse(8'h00, 1'b0, 1'b1);
`else
    chk("nochain_stage", stage, 32'd0);
    chk("nochain_alu_a", alu_a, 32'h05);
`endif
    chk("show_exit_rv", result_valid, 32'd0);

    // Counter wrap after 256 operations from reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 256; i++) begin
      run_op(8'h00, 8'h00, 2'd3, 8'h00, 5'b01000);
      leave_show();
    end
    chk("wrap_op_count", op_count, 32'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
